// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button presses -> count-enable/clear strobes for an external BCD counter.
// cnt_enable is combinational from state; cnt_clear is registered one cycle after a clear press; no backpressure.
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 4,
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_pause,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic [3:0] count_high,
  input  logic [3:0] count_low,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic [3:0] disp_high,
  output logic [3:0] disp_low,
  output logic       lap_active,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          lap_active_q, lap_active_d;
  logic [3:0]    lap_high_q, lap_high_d;
  logic [3:0]    lap_low_q, lap_low_d;
  logic          cnt_clear_q, cnt_clear_d;
  logic          btn_sp_q, btn_lap_q, btn_clr_q;

  logic press_sp, press_lap, press_clr;
  logic at_max, period_end;

  assign press_sp   = btn_start_pause & ~btn_sp_q;
  assign press_lap  = btn_lap & ~btn_lap_q;
  assign press_clr  = btn_clear & ~btn_clr_q;
  // Out-of-range BCD digits can never look like 99.
  assign at_max     = (count_high == 4'd9) && (count_low == 4'd9);
  assign period_end = (presc_q == PMAX);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    lap_active_d = lap_active_q;
    lap_high_d   = lap_high_q;
    lap_low_d    = lap_low_q;
    cnt_clear_d  = 1'b0;

    // Prescaler advances in every RUN cycle, including the one that pauses,
    // so a resume continues from where the partial period left off.
    if (state_q == RUN) begin
      presc_d = period_end ? '0 : presc_q + PW'(1);
      if (STOP_AT_MAX && at_max && period_end) begin
        state_d = DONE;
      end
    end

    if (press_clr) begin
      state_d      = IDLE;
      presc_d      = '0;
      lap_active_d = 1'b0;
      cnt_clear_d  = 1'b1;
    end else if (press_lap) begin
      if (state_q == RUN || state_q == PAUSE) begin
        lap_active_d = ~lap_active_q;
        if (!lap_active_q) begin
          lap_high_d = count_high;
          lap_low_d  = count_low;
        end
      end
    end else if (press_sp) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          presc_d = '0;
        end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      lap_active_q <= 1'b0;
      lap_high_q   <= 4'd0;
      lap_low_q    <= 4'd0;
      cnt_clear_q  <= 1'b0;
      btn_sp_q     <= 1'b0;
      btn_lap_q    <= 1'b0;
      btn_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      lap_active_q <= lap_active_d;
      lap_high_q   <= lap_high_d;
      lap_low_q    <= lap_low_d;
      cnt_clear_q  <= cnt_clear_d;
      btn_sp_q     <= btn_start_pause;
      btn_lap_q    <= btn_lap;
      btn_clr_q    <= btn_clear;
    end
  end

  assign cnt_enable = (state_q == RUN) && period_end && !(STOP_AT_MAX && at_max);
  assign cnt_clear  = cnt_clear_q;
  assign lap_active = lap_active_q;
  assign disp_high  = lap_active_q ? lap_high_q : count_high;
  assign disp_low   = lap_active_q ? lap_low_q  : count_low;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: two controllers (stop-at-99 and wrapping) each driving a behavioural BCD counter.
module tb_stopwatch_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Button vectors: {clear, lap, start_pause}
  logic [2:0] b1, b0;
  logic [7:0] c1, c0;
  logic       en1, clr1, lap1, en0, clr0, lap0;
  logic [3:0] dh1, dl1, dh0, dl0;
  logic [1:0] st1, st0;

  int n_checks;
  int n_fail;

  stopwatch_ctrl #(.TICK_DIV(4), .STOP_AT_MAX(1'b1)) dut1 (
    .clock(clock), .reset(reset),
    .btn_start_pause(b1[0]), .btn_lap(b1[1]), .btn_clear(b1[2]),
    .count_high(c1[7:4]), .count_low(c1[3:0]),
    .cnt_enable(en1), .cnt_clear(clr1),
    .disp_high(dh1), .disp_low(dl1),
    .lap_active(lap1), .state(st1)
  );

  stopwatch_ctrl #(.TICK_DIV(4), .STOP_AT_MAX(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .btn_start_pause(b0[0]), .btn_lap(b0[1]), .btn_clear(b0[2]),
    .count_high(c0[7:4]), .count_low(c0[3:0]),
    .cnt_enable(en0), .cnt_clear(clr0),
    .disp_high(dh0), .disp_low(dl0),
    .lap_active(lap0), .state(st0)
  );

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset || clr1) c1 <= 8'h00;
    else if (en1)       c1 <= bcd_inc(c1);
    if (!reset || clr0) c0 <= 8'h00;
    else if (en0)       c0 <= bcd_inc(c0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input bit which, input logic [2:0] mask);
    if (which) b1 = mask; else b0 = mask;
    @(negedge clock);
    if (which) b1 = 3'b000; else b0 = 3'b000;
  endtask

  task automatic wait_count(input bit which, input logic [7:0] target, input int budget);
    int n;
    n = 0;
    while (((which ? c1 : c0) != target) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_count", 32'(which ? c1 : c0), 32'(target));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    b1       = 3'b000;
    b0       = 3'b000;
    step(2);
    chk("rst_state", 32'(st1), 0);
    chk("rst_en", 32'(en1), 0);
    chk("rst_clr", 32'(clr1), 0);
    chk("rst_lap", 32'(lap1), 0);
    chk("rst_disp", 32'({dh1, dl1}), 32'h00);
    reset = 1'b1;
    step(1);

    pulse(1, 3'b010);
    chk("lap_in_idle", 32'(lap1), 0);

    // Start: strobes on the 4th, 8th and 12th cycle after the press.
    pulse(1, 3'b001);
    chk("start_state", 32'(st1), 1);
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("strobe_k%0d", k), 32'(en1), 32'((k % 4) == 0));
      step(1);
    end
    chk("count_03", 32'(c1), 32'h03);
    chk("disp_03", 32'({dh1, dl1}), 32'h03);

    // Pause at 05 with prescaler held at 2, then resume.
    wait_count(1, 8'h05, 20);
    step(1);
    pulse(1, 3'b001);
    chk("pause_state", 32'(st1), 2);
    for (int k = 0; k < 20; k++) begin
      chk("pause_no_strobe", 32'(en1), 0);
      step(1);
    end
    chk("pause_count", 32'(c1), 32'h05);
    pulse(1, 3'b001);
    chk("resume_state", 32'(st1), 1);
    chk("resume_r1_en", 32'(en1), 0);
    step(1);
    chk("resume_r2_en", 32'(en1), 1);
    step(1);
    chk("resume_count", 32'(c1), 32'h06);

    // Lap freeze at 17 while the counter reaches 20.
    wait_count(1, 8'h17, 60);
    pulse(1, 3'b010);
    chk("lap_on", 32'(lap1), 1);
    wait_count(1, 8'h20, 20);
    chk("lap_frozen", 32'({dh1, dl1}), 32'h17);
    pulse(1, 3'b010);
    chk("lap_off", 32'(lap1), 0);
    chk("lap_live", 32'({dh1, dl1}), 32'h20);

    // Terminal cycle with a simultaneous pause press: press wins.
    wait_count(1, 8'h99, 400);
    step(3);
    chk("no_strobe_99", 32'(en1), 0);
    b1 = 3'b001;
    step(1);
    b1 = 3'b000;
    chk("term_press_pause", 32'(st1), 2);
    step(1);
    pulse(1, 3'b001);
    chk("term_resume", 32'(st1), 1);
    step(4);
    chk("done_state", 32'(st1), 3);
    for (int k = 0; k < 50; k++) begin
      chk("done_no_strobe", 32'(en1), 0);
      step(1);
    end
    chk("done_count", 32'(c1), 32'h99);
    pulse(1, 3'b001);
    chk("done_sp_ignored", 32'(st1), 3);
    pulse(1, 3'b100);
    chk("clear_state", 32'(st1), 0);
    chk("clear_strobe", 32'(clr1), 1);
    chk("clear_no_en", 32'(en1), 0);
    step(1);
    chk("clear_one_cycle", 32'(clr1), 0);
    chk("clear_count", 32'(c1), 32'h00);

    // Wrapping variant: 99 -> 00 and keeps running.
    pulse(0, 3'b001);
    chk("wrap_start", 32'(st0), 1);
    wait_count(0, 8'h99, 500);
    wait_count(0, 8'h00, 10);
    chk("wrap_state", 32'(st0), 1);

    // Clear and start_pause together in RUN; held start_pause must not restart.
    pulse(1, 3'b001);
    step(5);
    b1 = 3'b101;
    step(1);
    chk("clr_sp_state", 32'(st1), 0);
    chk("clr_sp_strobe", 32'(clr1), 1);
    b1 = 3'b001;
    step(10);
    chk("held_sp_idle", 32'(st1), 0);
    chk("held_sp_no_clr", 32'(clr1), 0);
    b1 = 3'b000;
    step(1);
    pulse(1, 3'b001);
    chk("repress_run", 32'(st1), 1);

    // Reset mid-RUN at 42 with lap active.
    wait_count(1, 8'h42, 250);
    pulse(1, 3'b010);
    chk("pre_rst_lap", 32'(lap1), 1);
    reset = 1'b0;
    step(1);
    chk("midrst_state", 32'(st1), 0);
    chk("midrst_en", 32'(en1), 0);
    chk("midrst_lap", 32'(lap1), 0);
    reset = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the two-digit BCD 00–99 counter (count_high/count_low) as a stopwatch.
- Turns single-cycle button presses (start/pause, lap, clear) into count-enable and clear strobes for the counter.
- Divides the system clock into count ticks and freezes a lap value for display.
- Sits between the button/synchroniser logic and the counter plus 7-segment display path.

Parameters:
- TICK_DIV, 4, clock cycles per count tick in RUN; legal range 2..65535; prescaler width is $clog2(TICK_DIV).
- STOP_AT_MAX, 1, 1 = stop in DONE at 99; 0 = keep enabling so the external counter wraps 99->00.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_start_pause  in  1  level, already synchronised to clock.
- btn_lap  in  1  level, already synchronised.
- btn_clear  in  1  level, already synchronised.
- count_high  in  4  tens digit fed back from the counter, BCD 0..9.
- count_low  in  4  units digit fed back from the counter, BCD 0..9.
- cnt_enable  out  1  one-cycle increment strobe to the counter.
- cnt_clear  out  1  one-cycle clear strobe to the counter.
- disp_high  out  4  tens digit to display.
- disp_low  out  4  units digit to display.
- lap_active  out  1  display is showing the frozen lap value.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset: reset low at a rising edge gives the following on the next cycle:
  - state=IDLE, prescaler=0, lap_active=0, lap regs=0.
  - cnt_enable=0, cnt_clear=0.
  - Edge-detect flops=0.
  - Reset overrides every other input, including mid-RUN.
- Edge detect: press_x = btn_x & ~btn_x_q, where btn_x_q is the button registered each cycle. A held button gives exactly one press.
- Press priority in one cycle: clear > lap > start_pause. Lower-priority presses in that cycle are discarded.
- clear press, any state:
  - Next state IDLE, prescaler=0, lap_active=0.
  - cnt_clear registered high for exactly the next cycle.
- start_pause press:
  - IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - Ignored in DONE; only clear or reset leaves DONE.
- lap press:
  - In RUN or PAUSE: toggles lap_active. On 0->1, capture count_high/count_low as sampled that edge into the lap regs.
  - Ignored in IDLE and DONE; lap_active is held through DONE.
- Prescaler:
  - Increments every cycle in RUN and wraps at TICK_DIV-1.
  - Holds its value in PAUSE and DONE, so resume continues the partial period. It is 0 in IDLE.
- cnt_enable:
  - Combinational: (state==RUN) && (prescaler==TICK_DIV-1) && !(STOP_AT_MAX && count==99).
  - First strobe comes TICK_DIV cycles after entering RUN from IDLE.
- Terminal, STOP_AT_MAX=1:
  - In RUN, with count_high==9, count_low==9 and prescaler==TICK_DIV-1: next state DONE, no strobe.
  - A start_pause press that same cycle moves to PAUSE instead (press wins).
- Terminal, STOP_AT_MAX=0: DONE is unreachable.
- Display: disp_high/disp_low = lap regs when lap_active, else live count_high/count_low (combinational mux).
- cnt_enable and cnt_clear are never high in the same cycle.
- Out-of-range BCD inputs (>9) are passed to the display unchanged and never match the terminal check.

Test Plan (TICK_DIV=4, bench instantiates the real BCD counter):
- Reset, then pulse start_pause -> state=01. cnt_enable strobes on cycles 4, 8, 12 after the press. Count reads 03 after 12 cycles.
- Pause at count 05 mid-period (prescaler=2), hold 20 cycles, resume -> no strobes in PAUSE. Next strobe arrives 2 cycles after resume. Count goes to 06.
- Lap press at count 17 -> lap_active=1, display frozen at 17 while the counter reaches 20. Second lap press -> display shows live value 20.
- STOP_AT_MAX=1, run to 99 -> state=11, count stays 99 for 50 cycles, start_pause ignored. Clear -> cnt_clear for 1 cycle, state=00, count 00.
- STOP_AT_MAX=0, run past 99 -> count wraps 99->00, state stays 01.
- Clear and start_pause pressed in the same cycle during RUN -> state=00, cnt_clear pulse. Holding start_pause afterwards gives no restart until it is released and pressed again.
- Reset low mid-RUN at count 42 -> state=00 next cycle, cnt_enable=0, lap_active=0.
